// File: rtl/fifo_burst_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_rd_ctrl
// Brief    : Burst read controller between the UART FIFO read port and the
//            transmitter. Settles, then moves words into a valid/ready register.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_rd_ctrl #(
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 9,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 10,
    parameter int RD_LAT      = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              almost_full,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              rd_req,
    input  logic              mode,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              m_ready,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              busy,
    output logic              burst_done,
    output logic [CNT_W-1:0]  burst_cnt,
    output logic              short_burst
);

    localparam int c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_LAT_W = $clog2(RD_LAT + 1);

    localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE_CYC - 1);
    localparam logic [c_SET_W-1:0] c_SET_ONE     = c_SET_W'(1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST    = c_LAT_W'(RD_LAT);
    localparam logic [c_LAT_W-1:0] c_LAT_ONE     = c_LAT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ISSUE  = 3'd2,
        S_LAT    = 3'd3,
        S_HOLD   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               r_state;
    logic [SYNC_STAGES-1:0] r_af_sync;
    logic [c_SET_W-1:0]   r_settle_cnt;
    logic [c_LAT_W-1:0]   r_lat_cnt;
    logic                 r_mode;
    logic [CNT_W-1:0]     r_len;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_rd_en;
    logic [DATA_W-1:0]    r_m_data;
    logic                 r_m_valid;
    logic                 r_burst_done;
    logic                 r_short;
    logic                 w_af_sync;
    logic                 w_trigger;
    logic                 w_stop;

    // almost_full may originate in the write clock domain
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_af_sync <= '0;
        end else begin
            r_af_sync <= {r_af_sync[SYNC_STAGES-2:0], almost_full};
        end
    end

    assign w_af_sync = r_af_sync[SYNC_STAGES-1];
    assign w_trigger = w_af_sync | rd_req;
    // Length limit takes priority over empty; both end the burst the same way
    assign w_stop    = (r_mode && (r_cnt == r_len)) || empty;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_lat_cnt    <= '0;
            r_mode       <= 1'b0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_rd_en      <= 1'b0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_burst_done <= 1'b0;
            r_short      <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_burst_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_mode       <= mode;
                        r_len        <= burst_len;
                        r_cnt        <= '0;
                        r_short      <= 1'b0;
                        r_settle_cnt <= '0;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + c_SET_ONE;
                    end
                end
                S_ISSUE: begin
                    if (w_stop) begin
                        r_burst_done <= 1'b1;
                        r_short      <= r_mode && (r_cnt < r_len);
                        r_state      <= S_DONE;
                    end else begin
                        r_rd_en   <= 1'b1;
                        r_lat_cnt <= '0;
                        r_state   <= S_LAT;
                    end
                end
                S_LAT: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_m_data  <= fifo_dout;
                        r_m_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_LAT_ONE;
                    end
                end
                S_HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        if (r_cnt != c_CNT_MAX) begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en  = r_rd_en;
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign busy        = (r_state != S_IDLE);
    assign burst_done  = r_burst_done;
    assign burst_cnt   = r_cnt;
    assign short_burst = r_short;

endmodule
`default_nettype wire

// File: doc/fifo_burst_rd_ctrl.md
# fifo_burst_rd_ctrl

Parametrised read-side controller for the UART FIFO path, replacing the fixed threshold-triggered reader. On a synchronised almost-full flag or an explicit request it waits a configurable settle period. It then reads the FIFO one word at a time into a valid/ready output register, either draining to empty or stopping after a programmed burst length. It sits between the FIFO read port and the UART transmitter, and reports per-burst completion, word count and short-burst status.

## Interface
- DATA_W, 8: FIFO and output data width.
- CNT_W, 9: width of burst length and word counters (depth 256 needs 9).
- SYNC_STAGES, 2: synchroniser depth for `almost_full` (≥2).
- SETTLE_CYC, 10: cycles spent in SETTLE before the first read (≥1).
- RD_LAT, 1: FIFO read latency; `fifo_dout` is valid RD_LAT cycles after the cycle `fifo_rd_en` is high (≥1).

- sys_clk  in  1  clock; reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- sys_rst_n  in  1  asynchronous active-low reset.
- almost_full  in  1  FIFO almost-full; may come from the write clock domain, so it is synchronised internally.
- empty  in  1  FIFO empty, sys_clk domain.
- fifo_dout  in  DATA_W  FIFO read data.
- rd_req  in  1  single-cycle manual burst request.
- mode  in  1  0 = drain to empty, 1 = fixed burst.
- burst_len  in  CNT_W  word count for fixed mode.
- m_ready  in  1  downstream ready.
- fifo_rd_en  out  1  FIFO read enable, registered.
- m_data  out  DATA_W  output word.
- m_valid  out  1  output word valid.
- busy  out  1  high when state ≠ IDLE.
- burst_done  out  1  one-cycle pulse at burst end.
- burst_cnt  out  CNT_W  words delivered in the last burst; held until the next trigger.
- short_burst  out  1  set at burst end in fixed mode when burst_cnt < burst_len; held until the next trigger.

## Operation
- Reset values: all outputs 0, state IDLE, counters 0, synchroniser 0.
- `almost_full` passes through SYNC_STAGES flops; the trigger is `af_sync | rd_req` (level, not edge).
- **IDLE**
  - On trigger, latch `mode` and `burst_len`, clear `burst_cnt` and `short_burst`, and go to SETTLE.
  - `rd_req` is ignored outside IDLE.
- **SETTLE**
  - Stays exactly SETTLE_CYC cycles, then goes to ISSUE.
- **ISSUE**, priority order:
  1. If fixed mode and `burst_cnt == burst_len`, go to DONE.
  2. Else if `empty`, go to DONE.
  3. Else set `fifo_rd_en <= 1` and go to LAT.
- **LAT**
  - `fifo_rd_en` is high only in the first LAT cycle, so there is exactly one pulse per word.
  - LAT lasts RD_LAT+1 cycles.
  - On its last edge, capture `fifo_dout` into `m_data`, set `m_valid <= 1`, and go to HOLD.
- **HOLD**
  - `m_data` and `m_valid` are stable.
  - On an edge with `m_ready` = 1: clear `m_valid`, increment `burst_cnt` (saturates at all-ones), go to ISSUE.
- **DONE**
  - Pulse `burst_done` for one cycle.
  - Set `short_burst = mode & (burst_cnt < burst_len)`.
  - Go to IDLE.
- Retrigger: if `af_sync` is still high in IDLE, a new burst starts immediately, with a new SETTLE.
- Fixed mode with `burst_len` = 0 completes with no reads: `burst_cnt` = 0, `short_burst` = 0.
- Undefined state encodings go to IDLE with `fifo_rd_en` = 0.

## Timing
- Trigger to first `fifo_rd_en`:
  - `rd_req` sampled in IDLE at edge t: `fifo_rd_en` high in cycle t+SETTLE_CYC+2.
  - `almost_full` rise: add SYNC_STAGES cycles.
- `fifo_rd_en` high in cycle c: `m_valid` rises in cycle c+RD_LAT+1.
- Per-word period with `m_ready` held high: RD_LAT+3 cycles (ISSUE, LAT×(RD_LAT+1), HOLD).
- `empty` is sampled only in ISSUE, at least RD_LAT+2 cycles after the previous read. `fifo_rd_en` is never asserted while `empty` = 1.
- Last handshake to `burst_done`: 2 cycles (ISSUE, then the pulse in DONE). `busy` falls one cycle after the `burst_done` pulse.
- `m_ready` low in HOLD stalls indefinitely, with no further reads and no data change.
- Reset mid-burst:
  - Immediate return to IDLE; `m_valid`, `fifo_rd_en` and `busy` drop asynchronously.
  - A word in flight is discarded; no `burst_done`.

## Test plan
- **Drain, basic:** reset, FIFO holds 5 words, `rd_req` pulse with mode 0, `m_ready` = 1. Expect 5 `fifo_rd_en` pulses, 5 `m_valid` words in FIFO order, and `burst_done` with `burst_cnt` = 5 and `short_burst` = 0. With defaults, first `fifo_rd_en` is 12 cycles after `rd_req` and the word period is 4 cycles.
- **Fixed burst:** 20 words queued, mode 1, `burst_len` = 8, triggered via `almost_full`. Expect exactly 8 reads, `burst_cnt` = 8, then an immediate retrigger if `almost_full` stays high.
- **Short burst:** 3 words, mode 1, `burst_len` = 8. Expect 3 words, `burst_cnt` = 3, `short_burst` = 1, and no `fifo_rd_en` while `empty` is high.
- **Backpressure:** hold `m_ready` low for 50 cycles in HOLD. Expect `m_data` and `m_valid` stable, no `fifo_rd_en`, and one word accepted after release.
- **Edge cases:**
  - `burst_len` = 0 and an empty-at-trigger drain each produce `burst_done` with `burst_cnt` = 0 and zero reads.
  - `rd_req` while busy is ignored.
- **Reset mid-burst:** assert `sys_rst_n` low during LAT. Expect all outputs 0 at once and a clean new burst after release.
